// File: rtl/fnd_pkg.sv
// -----------------------------------------------------------------------------
// fnd_pkg
// Shared constants and helpers for the stopwatch 7-segment display path.
//   - SEG_*            : active-low segment patterns {g,f,e,d,c,b,a}
//   - DIGITS           : number of multiplexed display digits
//   - SCAN_COUNT_DEFAULT : clk cycles per digit slot (1 kHz at 100 MHz)
//   - DP_BLINK_THRESH  : centisecond threshold for the 1 Hz dp blink
//   - snap_t           : frame snapshot of the time fields and display mode
//   - bcd_ones/bcd_tens: 7-bit unsigned %10 and /10, truncated to 4 bits
// -----------------------------------------------------------------------------
package fnd_pkg;

  localparam int DIGITS             = 4;
  localparam int SCAN_COUNT_DEFAULT = 100_000;

  localparam logic [6:0] DP_BLINK_THRESH = 7'd50;

  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  typedef struct packed {
    logic       mode;   // 0 = sec.msec, 1 = hour.min
    logic [6:0] msec;
    logic [5:0] sec;
    logic [5:0] min;
    logic [4:0] hour;
  } snap_t;

  function automatic logic [3:0] bcd_ones(input logic [6:0] v);
    logic [6:0] r;
    r = v % 7'd10;
    return r[3:0];
  endfunction

  // Out-of-range values (e.g. 120) give a tens digit >= 10, which the
  // segment decoder blanks.
  function automatic logic [3:0] bcd_tens(input logic [6:0] v);
    logic [6:0] q;
    q = v / 7'd10;
    return q[3:0];
  endfunction

endpackage

// File: rtl/stopwatch_fnd_ctrl_if.sv
// -----------------------------------------------------------------------------
// stopwatch_fnd_ctrl_if
// Bundle between the stopwatch datapath / board and the FND controller.
//   sw_mode  : display mode (0 = sec.msec, 1 = hour.min)
//   msec/sec/min/hour : time fields from the datapath
//   fnd_com  : digit enables, active-low, bit 0 = rightmost digit
//   fnd_data : segments, active-low, {dp,g,f,e,d,c,b,a}
// master = datapath/board side, slave = display controller.
// -----------------------------------------------------------------------------
interface stopwatch_fnd_ctrl_if;
  logic       sw_mode;
  logic [6:0] msec;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hour;
  logic [3:0] fnd_com;
  logic [7:0] fnd_data;

  modport master (
    output sw_mode, msec, sec, min, hour,
    input  fnd_com, fnd_data
  );

  modport slave (
    input  sw_mode, msec, sec, min, hour,
    output fnd_com, fnd_data
  );
endinterface

// File: rtl/fnd_seg_decoder.sv
// -----------------------------------------------------------------------------
// fnd_seg_decoder
// Combinational BCD to active-low 7-segment decoder.
//   i_digit : 4-bit digit value; 10..15 decode to blank
//   o_seg   : active-low segments {g,f,e,d,c,b,a}
// -----------------------------------------------------------------------------
module fnd_seg_decoder
  import fnd_pkg::*;
(
  input  logic [3:0] i_digit,
  output logic [6:0] o_seg
);

  always_comb begin
    unique case (i_digit)
      4'd0:    o_seg = SEG_0;
      4'd1:    o_seg = SEG_1;
      4'd2:    o_seg = SEG_2;
      4'd3:    o_seg = SEG_3;
      4'd4:    o_seg = SEG_4;
      4'd5:    o_seg = SEG_5;
      4'd6:    o_seg = SEG_6;
      4'd7:    o_seg = SEG_7;
      4'd8:    o_seg = SEG_8;
      4'd9:    o_seg = SEG_9;
      default: o_seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/stopwatch_fnd_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_fnd_ctrl
// Scans a 4-digit common-anode 7-segment display from the stopwatch time
// fields. The fields and mode are snapshotted once per scan frame so that a
// frame always shows one coherent time value in one mode.
//   clk   : system clock
//   reset : asynchronous, active-high
//   bus   : stopwatch_fnd_ctrl_if.slave (time fields in, fnd_com/fnd_data out)
// Parameter SCAN_COUNT: clk cycles per digit slot (>= 2).
// -----------------------------------------------------------------------------
module stopwatch_fnd_ctrl
  import fnd_pkg::*;
#(
  parameter int SCAN_COUNT = SCAN_COUNT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 reset,
  stopwatch_fnd_ctrl_if.slave  bus
);

  localparam int CNT_W = (SCAN_COUNT > 2) ? $clog2(SCAN_COUNT) : 1;
  localparam int SEL_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_COUNT - 1);

  logic [CNT_W-1:0]  r_cnt;
  logic [SEL_W-1:0]  r_digit_sel;
  snap_t             r_snap;
  logic [DIGITS-1:0] r_fnd_com;
  logic [7:0]        r_fnd_data;

  logic       w_strobe;
  logic [6:0] w_src;
  logic [3:0] w_digit;
  logic [6:0] w_seg;
  logic       w_dp;

  assign w_strobe = (r_cnt == CNT_LAST);

  // Scan counter, digit select and frame snapshot.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  // NOTE: the snapshot is reset too, so the first frame shows a defined
  // all-zero time rather than whatever the datapath happens to present.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt       <= '0;
      r_digit_sel <= '0;
      r_snap      <= '0;
    end else if (w_strobe) begin
      r_cnt       <= '0;
      r_digit_sel <= r_digit_sel + 1'b1;
      // Capture at the end of the last slot so the next frame starts at
      // digit 0 with values that stay fixed for the whole frame.
      if (r_digit_sel == SEL_W'(DIGITS - 1)) begin
        r_snap.mode <= bus.sw_mode;
        r_snap.msec <= bus.msec;
        r_snap.sec  <= bus.sec;
        r_snap.min  <= bus.min;
        r_snap.hour <= bus.hour;
      end
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Digit mux: bit 1 picks the left/right pair, bit 0 picks tens/ones.
  // NOTE: every always_comb output gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    w_src   = '0;
    w_digit = '0;
    w_dp    = 1'b1;
    if (r_digit_sel[1])
      w_src = r_snap.mode ? {2'b00, r_snap.hour} : {1'b0, r_snap.sec};
    else
      w_src = r_snap.mode ? {1'b0, r_snap.min} : r_snap.msec;
    w_digit = r_digit_sel[0] ? bcd_tens(w_src) : bcd_ones(w_src);
    // Separator dp on digit 2 only; lit (0) for the first half of each
    // second in mode 0, on even seconds in mode 1.
    if (r_digit_sel == SEL_W'(2))
      w_dp = r_snap.mode ? r_snap.sec[0] : (r_snap.msec >= DP_BLINK_THRESH);
  end

  fnd_seg_decoder u_seg_dec (
    .i_digit (w_digit),
    .o_seg   (w_seg)
  );

  // Registered outputs: glitch-free pins, one clk behind digit_sel.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_fnd_com  <= '1;
      r_fnd_data <= 8'hFF;
    end else begin
      r_fnd_com  <= ~(DIGITS'(1) << r_digit_sel);
      r_fnd_data <= {w_dp, w_seg};
    end
  end

  assign bus.fnd_com  = r_fnd_com;
  assign bus.fnd_data = r_fnd_data;

endmodule
